timer_cmd_bridge: RTL and testbench

Upstream register master for d_ip_timer. It turns a byte-stream command channel (valid/ready) into single-cycle register accesses on the timer's addr/wdata/wr_en/mod_en bus. Read data is returned on a byte-stream response channel. It replaces direct bench register tasks with a synthesizable front end that a UART or SPI deserializer can drive.

---
 rtl/timer_cmd_bridge.sv | 134 +++++++++++++
 tb/tb_timer_cmd_bridge.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_cmd_bridge.sv
// Byte-stream command front end for d_ip_timer: decodes header/data bytes into
// single-cycle register strobes and returns read data on a response stream.
module timer_cmd_bridge #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        cmd_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              wr_en,
    output logic              mod_en,
    input  logic [DATA_W-1:0] rdata,
    output logic              cmd_err,
    output logic              busy
);

    localparam int CNT_W    = 16;
    localparam int LAT_LAST = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        WRITE,
        READ,
        READ_WAIT,
        RSP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cmd_hs;
    logic             rsp_hs;
    logic             err_nxt;
    logic             capture;

    assign cmd_hs = cmd_valid & cmd_ready;
    assign rsp_hs = rsp_valid & rsp_ready;

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_hs) begin
                    if (cmd_data[6]) begin
                        err_nxt = 1'b1;
                    end else if (cmd_data[7]) begin
                        state_nxt = READ;
                    end else begin
                        state_nxt = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                // A data byte landing on the final allowed cycle beats the timeout.
                if (cmd_hs) begin
                    state_nxt = WRITE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            READ: begin
                if (RD_LATENCY == 0) begin
                    capture   = 1'b1;
                    state_nxt = RSP;
                end else begin
                    state_nxt = READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (cnt == CNT_W'(LAT_LAST)) begin
                    capture   = 1'b1;
                    state_nxt = RSP;
                end
            end
            RSP: begin
                if (rsp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            cmd_err   <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            cmd_err   <= err_nxt;
            cmd_ready <= (state_nxt == IDLE) || (state_nxt == GET_DATA);
            // Counter restarts on every state entry; only GET_DATA and READ_WAIT consult it.
            cnt       <= (state_nxt == state) ? cnt + 1'b1 : '0;
            if (state == IDLE && cmd_hs) begin
                addr <= cmd_data[ADDR_W-1:0];
            end
            if (state == GET_DATA && cmd_hs) begin
                wdata <= cmd_data[DATA_W-1:0];
            end
            if (capture) begin
                rsp_data <= rdata;
            end
        end
    end

    assign mod_en    = (state == WRITE) || (state == READ);
    assign wr_en     = (state == WRITE);
    assign rsp_valid = (state == RSP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_timer_cmd_bridge.sv
// Bench for timer_cmd_bridge: directed and randomized command sequences checked
// cycle by cycle against a last-written-value register model.
module tb_timer_cmd_bridge;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;
    localparam int TMO    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        cmd_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr_en;
    logic              mod_en;
    logic [DATA_W-1:0] rdata;
    logic              cmd_err;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int strobes = 0;

    logic [7:0] tmem    [0:63];
    logic [7:0] ref_mem [0:63];
    bit         ref_wr  [0:63];

    always #5 clk = ~clk;

    timer_cmd_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .addr(addr), .wdata(wdata), .wr_en(wr_en), .mod_en(mod_en),
        .rdata(rdata), .cmd_err(cmd_err), .busy(busy)
    );

    // Timer stand-in: one-cycle read latency, random noise on rdata otherwise.
    always @(posedge clk) begin
        if (mod_en && wr_en) tmem[addr] <= wdata;
        rdata <= (mod_en && !wr_en) ? tmem[addr] : 8'($urandom);
        if (!rst && mod_en) strobes <= strobes + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  0);
        chk({tag, "_addr"},      32'(addr),      0);
        chk({tag, "_wdata"},     32'(wdata),     0);
        chk({tag, "_wr_en"},     32'(wr_en),     0);
        chk({tag, "_mod_en"},    32'(mod_en),    0);
        chk({tag, "_cmd_err"},   32'(cmd_err),   0);
        chk({tag, "_busy"},      32'(busy),      0);
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] d, input int gap);
        int s0;
        s0 = strobes;
        cmd_valid = 1'b1;
        cmd_data  = {2'b00, a};
        tick();
        cmd_valid = 1'b0;
        chk("wr_hdr_busy", 32'(busy), 1);
        chk("wr_hdr_ready", 32'(cmd_ready), 1);
        for (int i = 0; i < gap; i++) begin
            chk("wr_gap_no_strobe", 32'(mod_en), 0);
            chk("wr_gap_no_err", 32'(cmd_err), 0);
            tick();
        end
        cmd_valid = 1'b1;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        chk("wr_mod_en", 32'(mod_en), 1);
        chk("wr_wr_en", 32'(wr_en), 1);
        chk("wr_addr", 32'(addr), 32'(a));
        chk("wr_wdata", 32'(wdata), 32'(d));
        chk("wr_ready_low", 32'(cmd_ready), 0);
        chk("wr_no_err", 32'(cmd_err), 0);
        tick();
        chk("wr_done_busy", 32'(busy), 0);
        chk("wr_done_mod_en", 32'(mod_en), 0);
        chk("wr_done_ready", 32'(cmd_ready), 1);
        chk("wr_done_no_err", 32'(cmd_err), 0);
        chk("wr_strobe_count", strobes, s0 + 1);
        ref_mem[a] = d;
        ref_wr[a]  = 1'b1;
    endtask

    task automatic do_read(input logic [5:0] a, input int bp);
        int s0;
        logic [7:0] exp;
        s0  = strobes;
        exp = ref_mem[a];
        cmd_valid = 1'b1;
        cmd_data  = {2'b10, a};
        tick();
        cmd_valid = 1'b0;
        chk("rd_mod_en", 32'(mod_en), 1);
        chk("rd_wr_en", 32'(wr_en), 0);
        chk("rd_addr", 32'(addr), 32'(a));
        chk("rd_ready_low", 32'(cmd_ready), 0);
        chk("rd_no_vld", 32'(rsp_valid), 0);
        tick();
        chk("rd_wait_mod_en", 32'(mod_en), 0);
        chk("rd_wait_no_vld", 32'(rsp_valid), 0);
        tick();
        chk("rd_vld", 32'(rsp_valid), 1);
        chk("rd_data", 32'(rsp_data), 32'(exp));
        // A header offered while the bridge is busy must be ignored.
        for (int i = 0; i < bp; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = 8'h7F;
            tick();
            chk("rd_bp_vld", 32'(rsp_valid), 1);
            chk("rd_bp_data", 32'(rsp_data), 32'(exp));
            chk("rd_bp_ready_low", 32'(cmd_ready), 0);
            chk("rd_bp_no_err", 32'(cmd_err), 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_done_vld", 32'(rsp_valid), 0);
        chk("rd_done_ready", 32'(cmd_ready), 1);
        chk("rd_done_busy", 32'(busy), 0);
        chk("rd_strobe_count", strobes, s0 + 1);
    endtask

    task automatic do_bad(input logic [7:0] hdr);
        int s0;
        s0 = strobes;
        cmd_valid = 1'b1;
        cmd_data  = hdr;
        tick();
        cmd_valid = 1'b0;
        chk("bad_err", 32'(cmd_err), 1);
        chk("bad_busy", 32'(busy), 0);
        chk("bad_ready", 32'(cmd_ready), 1);
        chk("bad_mod_en", 32'(mod_en), 0);
        tick();
        chk("bad_err_clear", 32'(cmd_err), 0);
        chk("bad_no_strobe", strobes, s0);
    endtask

    task automatic do_timeout(input logic [5:0] a);
        int s0;
        s0 = strobes;
        cmd_valid = 1'b1;
        cmd_data  = {2'b00, a};
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            chk("to_busy", 32'(busy), 1);
            chk("to_no_err_yet", 32'(cmd_err), 0);
            tick();
        end
        chk("to_err", 32'(cmd_err), 1);
        chk("to_busy_clear", 32'(busy), 0);
        chk("to_ready", 32'(cmd_ready), 1);
        tick();
        chk("to_err_clear", 32'(cmd_err), 0);
        chk("to_no_strobe", strobes, s0);
    endtask

    task automatic ensure_written(input logic [5:0] a);
        if (!ref_wr[a]) do_write(a, 8'($urandom), 0);
    endtask

    task automatic recover_check(input string tag);
        rst = 1'b0;
        tick();
        chk({tag, "_ready"}, 32'(cmd_ready), 1);
        chk({tag, "_no_vld"}, 32'(rsp_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        tick();
        chk({tag, "_no_stale_vld"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        logic [5:0] ra;
        logic [7:0] rd;
        int         op;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();
        chk("post_reset_ready", 32'(cmd_ready), 1);
        chk("post_reset_busy", 32'(busy), 0);

        do_write(6'h05, 8'hA5, 0);
        do_read(6'h05, 0);
        do_read(6'h05, 5);
        do_bad(8'h45);
        do_timeout(6'h03);
        do_write(6'h03, 8'h3C, TMO - 1);
        do_read(6'h03, 1);

        // Reset while waiting for read data.
        cmd_valid = 1'b1;
        cmd_data  = 8'h85;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk_zero("rst_wait");
        recover_check("rst_wait_rel");

        // Reset while a response is pending.
        cmd_valid = 1'b1;
        cmd_data  = 8'h83;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("rst_rsp_pre_vld", 32'(rsp_valid), 1);
        rst = 1'b1;
        tick();
        chk_zero("rst_rsp");
        recover_check("rst_rsp_rel");
        do_read(6'h03, 0);

        for (int k = 0; k < 40; k++) begin
            ra = 6'($urandom);
            rd = 8'($urandom);
            op = int'($urandom_range(0, 4));
            case (op)
                0, 1: do_write(ra, rd, int'($urandom_range(0, TMO - 1)));
                2: begin
                    ensure_written(ra);
                    do_read(ra, int'($urandom_range(0, 3)));
                end
                3: do_bad({1'($urandom), 1'b1, ra});
                default: do_timeout(ra);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
